// File: rtl/link_pkg.sv
// Shared definitions for the paddle-position link: frame field codes, receiver
// state encoding and the 7-bit checksum used by both the framer and the deframer.
package link_pkg;

  localparam logic       HDR_MARK  = 1'b1;
  localparam logic [1:0] MSG_POS   = 2'b00;
  localparam logic [7:0] TYPE_MASK = 8'b0110_0000;
  localparam logic [7:0] RSVD_MASK = 8'b0001_1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DAT = 2'd1,
    WAIT_CHK = 2'd2
  } rx_state_t;

  function automatic logic [6:0] chk7(input logic [7:0] hdr, input logic [7:0] dat);
    return 7'(hdr ^ dat);
  endfunction

  // A header must carry the resync marker, the position type and zero reserved bits.
  function automatic logic is_valid_hdr(input logic [7:0] b);
    return (b[7] == HDR_MARK) && (b[6:5] == MSG_POS) && ((b & RSVD_MASK) == 8'h00);
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Saturating idle counter: cleared by kick, counts while enabled, flags once LIMIT is reached.
module link_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  input  logic ena,
  output logic expired
);

  localparam int unsigned   CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (ena && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = ena && (cnt_q == LIM);

endmodule

// File: rtl/pos_link_rx.sv
// Receive side of the paddle-position link: deframes HDR/DAT/CHK byte triples from the
// UART, drives the opponent paddle position and reports link health.
module pos_link_rx
  import link_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 65_000,
  parameter int unsigned LINK_TIMEOUT = 6_500_000,
  parameter logic [9:0]  MAX_POS      = 10'd668,
  parameter logic [9:0]  RESET_POS    = 10'd334
) (
  input  logic       clk65MHz,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] input_pos,
  output logic       pos_valid,
  output logic       link_up,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  rx_state_t  state_q, state_d;
  logic [6:0] hdr_q, hdr_d;
  logic [6:0] dat_q, dat_d;
  logic [9:0] input_pos_q, input_pos_d;
  logic       pos_valid_q, link_up_q, link_up_d, frame_err_q;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       commit, err;
  logic       byte_kick, byte_exp, link_exp;

  function automatic logic [9:0] clamp_pos(input logic [9:0] pos);
    return (pos > MAX_POS) ? MAX_POS : pos;
  endfunction

  // The byte timer is held clear in IDLE so every frame starts with a full budget.
  assign byte_kick = rx_valid || (state_q == IDLE);

  link_watchdog #(.LIMIT(BYTE_TIMEOUT)) u_byte_wd (
    .clk     (clk65MHz),
    .rst_n   (rst_n),
    .kick    (byte_kick),
    .ena     (state_q != IDLE),
    .expired (byte_exp)
  );

  link_watchdog #(.LIMIT(LINK_TIMEOUT)) u_link_wd (
    .clk     (clk65MHz),
    .rst_n   (rst_n),
    .kick    (commit),
    .ena     (1'b1),
    .expired (link_exp)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    dat_d   = dat_q;
    commit  = 1'b0;
    err     = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (is_valid_hdr(rx_data)) begin
            hdr_d   = rx_data[6:0];
            state_d = WAIT_DAT;
          end else if (rx_data[7]) begin
            err = 1'b1;
          end
        end
        WAIT_DAT: begin
          if (!rx_data[7]) begin
            dat_d   = rx_data[6:0];
            state_d = WAIT_CHK;
          end else if (is_valid_hdr(rx_data)) begin
            hdr_d = rx_data[6:0];
            err   = 1'b1;
          end else begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT_CHK: begin
          if (!rx_data[7]) begin
            if (rx_data[6:0] == chk7({HDR_MARK, hdr_q}, {1'b0, dat_q})) begin
              commit = 1'b1;
            end else begin
              err = 1'b1;
            end
            state_d = IDLE;
          end else if (is_valid_hdr(rx_data)) begin
            hdr_d   = rx_data[6:0];
            err     = 1'b1;
            state_d = WAIT_DAT;
          end else begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (byte_exp) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  // Commit takes priority over link loss when both land in the same cycle.
  always_comb begin
    input_pos_d = input_pos_q;
    link_up_d   = link_up_q;
    if (commit) begin
      input_pos_d = clamp_pos({hdr_q[2:0], dat_q});
      link_up_d   = 1'b1;
    end else if (link_exp) begin
      input_pos_d = RESET_POS;
      link_up_d   = 1'b0;
    end
    err_cnt_d = err_cnt_q;
    if (err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      input_pos_q <= RESET_POS;
      pos_valid_q <= 1'b0;
      link_up_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      input_pos_q <= input_pos_d;
      pos_valid_q <= commit;
      link_up_q   <= link_up_d;
      frame_err_q <= err;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk65MHz) begin
    hdr_q <= hdr_d;
    dat_q <= dat_d;
  end

  assign input_pos = input_pos_q;
  assign pos_valid = pos_valid_q;
  assign link_up   = link_up_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pos_link_rx.sv
// Bench for pos_link_rx: directed frames plus randomized frame mixes against a frame-level model.
module tb_pos_link_rx;

  logic       clk65MHz = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] input_pos;
  logic       pos_valid, link_up, frame_err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt   = 0;
  int fe_cnt   = 0;

  always #5 clk65MHz = ~clk65MHz;

  pos_link_rx #(
    .BYTE_TIMEOUT (20),
    .LINK_TIMEOUT (200),
    .MAX_POS      (10'd668),
    .RESET_POS    (10'd334)
  ) dut (
    .clk65MHz  (clk65MHz),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .input_pos (input_pos),
    .pos_valid (pos_valid),
    .link_up   (link_up),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk65MHz) begin
    if (rst_n) begin
      if (pos_valid) pv_cnt++;
      if (frame_err) fe_cnt++;
      if (pos_valid && frame_err) expect_eq("pv_fe_exclusive", 1, 0);
    end
  end

  function automatic logic [7:0] hdr_of(input int p);
    logic [9:0] v;
    v = 10'(p);
    return {1'b1, 4'b0000, v[9:7]};
  endfunction

  function automatic logic [7:0] dat_of(input int p);
    logic [9:0] v;
    v = 10'(p);
    return {1'b0, v[6:0]};
  endfunction

  function automatic logic [7:0] chk_of(input int p);
    logic [7:0] x;
    x = hdr_of(p) ^ dat_of(p);
    return {1'b0, x[6:0]};
  endfunction

  function automatic int clamp(input int p);
    return (p > 668) ? 668 : p;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk65MHz);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk65MHz);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk65MHz);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int exp_pos, exp_err, pv0, fe0, first, kind, p, p2, bad_run, exp_pv, exp_fe;
    logic [7:0] b;

    // Power-on reset
    repeat (3) @(negedge clk65MHz);
    expect_eq("rst_pos", input_pos, 334);
    expect_eq("rst_link", link_up, 0);
    expect_eq("rst_errcnt", err_cnt, 0);
    expect_eq("rst_pv", pos_valid, 0);
    expect_eq("rst_fe", frame_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk65MHz);

    // Good frame with exact one-cycle pos_valid latency
    send_byte(8'h83, 0);
    send_byte(8'h74, 0);
    @(negedge clk65MHz);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    expect_eq("good_pv_before", pos_valid, 0);
    @(negedge clk65MHz);
    rx_valid = 1'b0;
    expect_eq("good_pv_pulse", pos_valid, 1);
    expect_eq("good_pos", input_pos, 500);
    expect_eq("good_link", link_up, 1);
    @(negedge clk65MHz);
    expect_eq("good_pv_drop", pos_valid, 0);

    // Asynchronous reset mid-frame after an error
    send_byte(8'h88, 1);
    expect_eq("badhdr_errcnt", err_cnt, 1);
    send_byte(8'h83, 0);
    send_byte(8'h74, 0);
    #3 rst_n = 1'b0;
    #1;
    expect_eq("midrst_pos", input_pos, 334);
    expect_eq("midrst_link", link_up, 0);
    expect_eq("midrst_errcnt", err_cnt, 0);
    @(negedge clk65MHz);
    rst_n = 1'b1;
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h77, 2);
    expect_eq("midrst_idle_pv", pv_cnt - pv0, 0);
    expect_eq("midrst_idle_fe", fe_cnt - fe0, 0);
    exp_err = 0;

    // Clamp
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h87, 0); send_byte(8'h68, 0); send_byte(8'h6F, 2);
    expect_eq("clamp_pos", input_pos, 668);
    expect_eq("clamp_pv", pv_cnt - pv0, 1);
    expect_eq("clamp_fe", fe_cnt - fe0, 0);
    expect_eq("clamp_link", link_up, 1);

    // Bad checksum
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h83, 0); send_byte(8'h74, 0); send_byte(8'h76, 2);
    exp_err++;
    expect_eq("badchk_fe", fe_cnt - fe0, 1);
    expect_eq("badchk_errcnt", err_cnt, exp_err);
    expect_eq("badchk_pos", input_pos, 668);
    expect_eq("badchk_pv", pv_cnt - pv0, 0);

    // Resync on a repeated header, then a lone data byte in IDLE
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h83, 0); send_byte(8'h83, 0); send_byte(8'h74, 0); send_byte(8'h77, 2);
    exp_err++;
    expect_eq("resync_fe", fe_cnt - fe0, 1);
    expect_eq("resync_pos", input_pos, 500);
    expect_eq("resync_pv", pv_cnt - pv0, 1);
    fe0 = fe_cnt;
    send_byte(8'h74, 2);
    expect_eq("lone_fe", fe_cnt - fe0, 0);
    expect_eq("lone_errcnt", err_cnt, exp_err);

    // Byte timeout
    fe0 = fe_cnt; first = -1;
    send_byte(8'h83, 0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk65MHz);
      if (frame_err && first < 0) first = i;
    end
    exp_err++;
    expect_eq("byteto_window", (first >= 20 && first <= 22), 1);
    expect_eq("byteto_fe", fe_cnt - fe0, 1);
    expect_eq("byteto_errcnt", err_cnt, exp_err);
    pv0 = pv_cnt;
    send_byte(8'h74, 0); send_byte(8'h77, 2);
    expect_eq("byteto_idle_pv", pv_cnt - pv0, 0);

    // Randomized frame mix against the frame-level model
    exp_pos = 500; bad_run = 0;
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 4);
      if (bad_run >= 3) kind = 0;
      p  = $urandom_range(0, 1023);
      p2 = $urandom_range(0, 1023);
      pv0 = pv_cnt; fe0 = fe_cnt; exp_pv = 0; exp_fe = 0;
      case (kind)
        0: begin
          send_byte(hdr_of(p), $urandom_range(0, 3));
          send_byte(dat_of(p), $urandom_range(0, 3));
          send_byte(chk_of(p), 0);
          exp_pv = 1; exp_pos = clamp(p);
        end
        1: begin
          b = chk_of(p) ^ (8'h01 << $urandom_range(0, 6));
          send_byte(hdr_of(p), $urandom_range(0, 3));
          send_byte(dat_of(p), $urandom_range(0, 3));
          send_byte(b, 0);
          exp_fe = 1;
        end
        2: begin
          b = {1'b1, 4'($urandom_range(1, 15)), 3'($urandom_range(0, 7))};
          send_byte(b, 0);
          exp_fe = 1;
        end
        3: begin
          b = 8'($urandom_range(0, 127));
          send_byte(b, 0);
        end
        default: begin
          send_byte(hdr_of(p), $urandom_range(0, 3));
          send_byte(hdr_of(p2), $urandom_range(0, 3));
          send_byte(dat_of(p2), $urandom_range(0, 3));
          send_byte(chk_of(p2), 0);
          exp_pv = 1; exp_fe = 1; exp_pos = clamp(p2);
        end
      endcase
      bad_run = exp_pv ? 0 : bad_run + 1;
      exp_err = (exp_err + exp_fe > 255) ? 255 : exp_err + exp_fe;
      repeat (2) @(negedge clk65MHz);
      expect_eq("rnd_pv", pv_cnt - pv0, exp_pv);
      expect_eq("rnd_fe", fe_cnt - fe0, exp_fe);
      expect_eq("rnd_pos", input_pos, exp_pos);
      expect_eq("rnd_errcnt", err_cnt, exp_err);
      expect_eq("rnd_link", link_up, 1);
    end

    // Link timeout
    send_byte(8'h83, 0); send_byte(8'h74, 0); send_byte(8'h77, 0);
    repeat (150) @(negedge clk65MHz);
    expect_eq("link_hold", link_up, 1);
    expect_eq("link_hold_pos", input_pos, 500);
    repeat (80) @(negedge clk65MHz);
    expect_eq("link_drop", link_up, 0);
    expect_eq("link_drop_pos", input_pos, 334);

    // Error counter saturation
    fe0 = fe_cnt;
    for (int i = 0; i < 300; i++) send_byte(8'h88, 0);
    repeat (2) @(negedge clk65MHz);
    expect_eq("sat_fe", fe_cnt - fe0, 300);
    expect_eq("sat_errcnt", err_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
